// File: rtl/scs8hd_o21a_bist.sv
`default_nettype none
// ============================================================================
//  Module      : scs8hd_o21a_bist
//  Description : Exhaustive built-in self test for an o21a-class cell,
//                X = (A1 | A2) & B1. Walks all eight {A1,A2,B1} vectors,
//                waits SETTLE cycles per vector, then samples the cell
//                response and counts mismatches.
//  Revision    : 1.0 - initial release
// ============================================================================
module scs8hd_o21a_bist #(
  parameter int unsigned SETTLE = 2          // legal range 1..15
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic       DUT_X,
  output logic       A1_O,
  output logic       A2_O,
  output logic       B1_O,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [3:0] ERR_CNT,
  output logic [2:0] FAIL_VEC
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_FIN    = 2'd3
  } state_t;

  localparam logic [3:0] C_RELOAD  = 4'(SETTLE - 1);
  localparam logic [2:0] C_LAST    = 3'd7;
  localparam logic [3:0] C_ERR_MAX = 4'd15;

  state_t     state_q;
  logic [2:0] vec_q;
  logic [3:0] cnt_q;
  logic [3:0] err_cnt_q;
  logic [2:0] fail_vec_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;

  logic       w_exp;
  logic       w_match;
  logic [3:0] w_err_next;

  // Expected cell response and compare; an X/Z response fails the equality
  // test, so it falls through as a mismatch.
  always_comb begin
    w_exp   = (vec_q[2] | vec_q[1]) & vec_q[0];
    w_match = 1'b0;
    if (DUT_X == w_exp) begin
      w_match = 1'b1;
    end
    w_err_next = (err_cnt_q == C_ERR_MAX) ? err_cnt_q : err_cnt_q + 4'd1;
  end

  // Test sequencer: start, per-vector settle wait, sample, and finish.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_IDLE;
      vec_q      <= 3'd0;
      cnt_q      <= 4'd0;
      err_cnt_q  <= 4'd0;
      fail_vec_q <= 3'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_FIN: begin
          if (START) begin
            state_q    <= S_SETTLE;
            vec_q      <= 3'd0;
            cnt_q      <= C_RELOAD;
            err_cnt_q  <= 4'd0;
            fail_vec_q <= 3'd0;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_SAMPLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_SAMPLE: begin
          if (!w_match) begin
            err_cnt_q <= w_err_next;
            if (err_cnt_q == 4'd0) begin
              fail_vec_q <= vec_q;
            end
          end
          if (vec_q == C_LAST) begin
            state_q <= S_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            // The final sample must also be clean for a pass.
            pass_q  <= w_match && (err_cnt_q == 4'd0);
          end else begin
            vec_q   <= vec_q + 3'd1;
            cnt_q   <= C_RELOAD;
            state_q <= S_SETTLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign A1_O     = vec_q[2];
  assign A2_O     = vec_q[1];
  assign B1_O     = vec_q[0];
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign PASS     = pass_q;
  assign ERR_CNT  = err_cnt_q;
  assign FAIL_VEC = fail_vec_q;

endmodule
`default_nettype wire

// File: tb/tb_scs8hd_o21a_bist.sv
`default_nettype none
// ============================================================================
//  Module      : tb_scs8hd_o21a_bist
//  Description : Self-checking bench for scs8hd_o21a_bist. Two instances
//                (SETTLE=1 and SETTLE=2) each see a modelled cell whose
//                response is a truth table indexed by the stimulus vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_scs8hd_o21a_bist;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0, start_b = 1'b0;
  logic [7:0] tt_a = 8'h00, tt_b = 8'h00;

  logic       a1_a, a2_a, b1_a, busy_a, done_a, pass_a;
  logic       a1_b, a2_b, b1_b, busy_b, done_b, pass_b;
  logic [3:0] err_a, err_b;
  logic [2:0] fv_a, fv_b;
  logic       x_a, x_b;

  int checks = 0;
  int errors = 0;
  int sel    = 2;   // which instance the observation wires show

  logic       o_busy, o_done, o_pass;
  logic [3:0] o_err;
  logic [2:0] o_fv, o_vec;

  always #5 clk = ~clk;

  // Cell models: response is the truth-table bit selected by {A1,A2,B1}.
  assign x_a = tt_a[{a1_a, a2_a, b1_a}];
  assign x_b = tt_b[{a1_b, a2_b, b1_b}];

  assign o_busy = (sel == 1) ? busy_a : busy_b;
  assign o_done = (sel == 1) ? done_a : done_b;
  assign o_pass = (sel == 1) ? pass_a : pass_b;
  assign o_err  = (sel == 1) ? err_a  : err_b;
  assign o_fv   = (sel == 1) ? fv_a   : fv_b;
  assign o_vec  = (sel == 1) ? {a1_a, a2_a, b1_a} : {a1_b, a2_b, b1_b};

  scs8hd_o21a_bist #(.SETTLE(1)) u_dut_s1 (
    .CLK(clk), .RESET(rst), .START(start_a), .DUT_X(x_a),
    .A1_O(a1_a), .A2_O(a2_a), .B1_O(b1_a),
    .BUSY(busy_a), .DONE(done_a), .PASS(pass_a),
    .ERR_CNT(err_a), .FAIL_VEC(fv_a)
  );

  scs8hd_o21a_bist #(.SETTLE(2)) u_dut_s2 (
    .CLK(clk), .RESET(rst), .START(start_b), .DUT_X(x_b),
    .A1_O(a1_b), .A2_O(a2_b), .B1_O(b1_b),
    .BUSY(busy_b), .DONE(done_b), .PASS(pass_b),
    .ERR_CNT(err_b), .FAIL_VEC(fv_b)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Golden o21a truth table built from the cell function.
  function automatic logic [7:0] golden_tt();
    logic [7:0] t;
    for (int v = 0; v < 8; v++) begin
      t[v] = ((((v >> 2) | (v >> 1)) & v) & 1) != 0;
    end
    return t;
  endfunction

  task automatic set_start(input int which, input logic val);
    if (which == 1) start_a = val;
    else            start_b = val;
  endtask

  // One complete run: pulse START, follow the run, compare with the model.
  task automatic run(input int which, input logic [7:0] tt, input string tag,
                     input int repulse_k);
    int         s      = (which == 1) ? 1 : 2;
    int         n      = 8 * (s + 1);
    logic [7:0] gold   = golden_tt();
    int         e_err  = 0;
    int         e_fv   = 0;
    int         done_k = 0;
    int         busy_n = 0;
    sel = which;
    if (which == 1) tt_a = tt; else tt_b = tt;
    for (int v = 7; v >= 0; v--) begin
      if (tt[v] != gold[v]) begin
        e_err++;
        e_fv = v;
      end
    end
    set_start(which, 1'b1);
    for (int k = 1; k <= n + 10; k++) begin
      @(negedge clk);
      if (k == 1) set_start(which, 1'b0);
      if (k == repulse_k)     set_start(which, 1'b1);
      if (k == repulse_k + 1) set_start(which, 1'b0);
      if (o_busy) busy_n++;
      if (k <= n) chk({tag, "_vec"}, int'(o_vec), (k - 1) / (s + 1));
      if (o_done) begin
        done_k = k;
        break;
      end
    end
    chk({tag, "_latency"}, done_k - 1, n);
    chk({tag, "_busy_cycles"}, busy_n, n);
    chk({tag, "_err"}, int'(o_err), e_err);
    chk({tag, "_pass"}, int'(o_pass), (e_err == 0) ? 1 : 0);
    if (e_err != 0) chk({tag, "_failvec"}, int'(o_fv), e_fv);
    repeat (3) @(negedge clk);
    chk({tag, "_done_held"}, int'({o_done, o_busy, o_pass}),
        {1'b1, 1'b0, (e_err == 0)});
  endtask

  initial begin
    logic [7:0] gold;
    gold = golden_tt();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    sel = 1;
    chk("reset_s1", int'({o_busy, o_done, o_pass, o_err, o_fv, o_vec}), 0);
    sel = 2;
    chk("reset_s2", int'({o_busy, o_done, o_pass, o_err, o_fv, o_vec}), 0);

    run(2, gold,  "golden_s2", 0);
    run(2, 8'h00, "stuck0_s2", 0);
    run(2, 8'hFF, "stuck1_s2", 0);
    run(1, gold,  "golden_s1_repulse", 5);
    for (int r = 0; r < 4; r++) begin
      run(2, 8'($urandom_range(0, 255)), $sformatf("rand%0d_s2", r), 0);
      run(1, 8'($urandom_range(0, 255)), $sformatf("rand%0d_s1", r), 0);
    end

    // Reset during vector 4 (SETTLE=2: vector 4 spans cycles 13..15).
    sel  = 2;
    tt_b = gold;
    start_b = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk);
      if (k == 1) start_b = 1'b0;
    end
    chk("midrun_vec_before", int'(o_vec), 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrun_reset_outs", int'({o_busy, o_done, o_pass, o_err, o_fv, o_vec}), 0);
    @(negedge clk);
    chk("midrun_stays_idle", int'({o_busy, o_done, o_vec}), 0);
    run(2, gold, "after_reset_s2", 0);

    // Back-to-back runs with START held high on a stuck-at-0 cell.
    tt_b    = 8'h00;
    start_b = 1'b1;
    begin
      int done_k = 0;
      for (int k = 1; k <= 40; k++) begin
        @(negedge clk);
        if (o_done) begin
          done_k = k;
          break;
        end
      end
      chk("b2b_latency", done_k - 1, 24);
      chk("b2b_err_first", int'(o_err), 3);
      @(negedge clk);
      chk("b2b_restart", int'({o_done, o_busy, o_err, o_vec}), {1'b0, 1'b1, 4'd0, 3'd0});
    end
    start_b = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
